// File: rtl/my_uart_pkg.sv
// Shared types and width constants for the my_uart_core UART echo block.
package my_uart_pkg;

  localparam int unsigned N_DEF       = 8;
  localparam int unsigned PSCALER_DEF = 2;
  localparam int unsigned DIV_DEF     = 10;

  localparam int unsigned BIT_CNT_W  = $clog2(N_DEF + 1);
  localparam int unsigned TICK_CNT_W = $clog2(DIV_DEF);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/my_uart_tick_gen.sv
// Free-running prescaler: one-cycle oversample tick every PSCALER sysclk cycles.
module uart_tick_gen
  import my_uart_pkg::*;
#(
  parameter int unsigned PSCALER = PSCALER_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
  localparam logic [CW-1:0] LAST = CW'(PSCALER - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/my_uart_core.sv
// 8N1-style UART echo: receive frames on rx_i, retransmit each valid byte on tx_o.
module my_uart_core
  import my_uart_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned PSCALER = PSCALER_DEF,
  parameter int unsigned DIV     = DIV_DEF
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic rx_i,
  output logic tx_o
);

  localparam int unsigned BCW = ($clog2(N + 1) > BIT_CNT_W) ? $clog2(N + 1) : BIT_CNT_W;
  localparam int unsigned TCW = ($clog2(DIV) > TICK_CNT_W) ? $clog2(DIV) : TICK_CNT_W;
  localparam logic [TCW-1:0] HALF_LAST = TCW'(DIV / 2 - 1);
  localparam logic [TCW-1:0] BIT_LAST  = TCW'(DIV - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(N - 1);

  logic tick;

  uart_tick_gen #(.PSCALER(PSCALER)) u_tick (
    .clk_i (sysclk),
    .rst_ni(reset_n),
    .tick_o(tick)
  );

  logic [1:0] rx_sync_q;
  logic       rx_s;
  assign rx_s = rx_sync_q[1];

  rx_state_t      rx_state_q, rx_state_d;
  logic [TCW-1:0] rx_tcnt_q, rx_tcnt_d;
  logic [BCW-1:0] rx_bcnt_q, rx_bcnt_d;
  logic [N-1:0]   rx_shift_q, rx_shift_d;
  logic           rx_done;

  logic           buf_full_q, buf_full_d;
  logic [N-1:0]   buf_q, buf_d;

  tx_state_t      tx_state_q, tx_state_d;
  logic [TCW-1:0] tx_tcnt_q, tx_tcnt_d;
  logic [BCW-1:0] tx_bcnt_q, tx_bcnt_d;
  logic [N-1:0]   tx_shift_q, tx_shift_d;
  logic           tx_q, tx_d;
  logic           tx_take;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: if (tick && !rx_s) begin
        rx_state_d = RX_START;
        rx_tcnt_d  = '0;
      end
      RX_START: if (tick) begin
        if (rx_tcnt_q == HALF_LAST) begin
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else rx_tcnt_d = rx_tcnt_q + 1'b1;
      end
      RX_DATA: if (tick) begin
        if (rx_tcnt_q == BIT_LAST) begin
          rx_tcnt_d  = '0;
          rx_shift_d = {rx_s, rx_shift_q[N-1:1]};
          rx_bcnt_d  = rx_bcnt_q + 1'b1;
          if (rx_bcnt_q == DATA_LAST) rx_state_d = RX_STOP;
        end else rx_tcnt_d = rx_tcnt_q + 1'b1;
      end
      RX_STOP: if (tick) begin
        if (rx_tcnt_q == BIT_LAST) begin
          rx_tcnt_d  = '0;
          rx_done    = rx_s;
          rx_state_d = rx_s ? RX_IDLE : RX_WAIT_IDLE;
        end else rx_tcnt_d = rx_tcnt_q + 1'b1;
      end
      RX_WAIT_IDLE: if (rx_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // STOP reloads straight from the buffer so queued bytes go out back-to-back.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_take    = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: if (tick && buf_full_q) begin
        tx_take    = 1'b1;
        tx_shift_d = buf_q;
        tx_d       = 1'b0;
        tx_tcnt_d  = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tick) begin
        if (tx_tcnt_q == BIT_LAST) begin
          tx_tcnt_d  = '0;
          tx_bcnt_d  = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else tx_tcnt_d = tx_tcnt_q + 1'b1;
      end
      TX_DATA: if (tick) begin
        if (tx_tcnt_q == BIT_LAST) begin
          tx_tcnt_d = '0;
          if (tx_bcnt_q == DATA_LAST) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_d       = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[N-1:1]};
            tx_bcnt_d  = tx_bcnt_q + 1'b1;
          end
        end else tx_tcnt_d = tx_tcnt_q + 1'b1;
      end
      TX_STOP: if (tick) begin
        if (tx_tcnt_q == BIT_LAST) begin
          tx_tcnt_d = '0;
          if (buf_full_q) begin
            tx_take    = 1'b1;
            tx_shift_d = buf_q;
            tx_d       = 1'b0;
            tx_state_d = TX_START;
          end else tx_state_d = TX_IDLE;
        end else tx_tcnt_d = tx_tcnt_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (rx_done && (!buf_full_q || tx_take)) begin
      buf_full_d = 1'b1;
      buf_d      = rx_shift_q;
    end else if (tx_take) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_q  <= '1;
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shift_q <= '0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx_i};
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shift_q <= rx_shift_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_my_uart_core.sv
// Bench for my_uart_core: frame-level line driver, tx_o frame decoder and byte-queue echo model.
module tb_my_uart_core;

  localparam int unsigned PSC   = 2;
  localparam int unsigned DIVP  = 10;
  localparam int unsigned BIT   = PSC * DIVP;
  localparam int unsigned FRAME = 10 * BIT;
  localparam int unsigned NRAND = 16;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;
  logic rx_i    = 1'b1;
  logic tx_o;

  my_uart_core #(.N(8), .PSCALER(PSC), .DIV(DIVP)) dut (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .rx_i   (rx_i),
    .tx_o   (tx_o)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Decoded echo frames, one entry per complete frame seen on tx_o.
  typedef struct {
    logic [7:0] data;
    int         start;
    bit         widths_ok;
    bit         framing_ok;
  } echo_t;

  echo_t mon_q[$];
  bit    mon_busy  = 1'b0;
  int    mon_start = 0;
  int    tx_low_cnt = 0;

  always @(negedge sysclk) if (tx_o !== 1'b1) tx_low_cnt <= tx_low_cnt + 1;

  initial begin : monitor
    logic             prev;
    logic [FRAME-1:0] smp;
    bit               aborted;
    bit               wok;
    echo_t            e;
    prev = 1'b1;
    forever begin
      @(negedge sysclk);
      if (reset_n === 1'b1 && prev === 1'b1 && tx_o === 1'b0) begin
        mon_busy  = 1'b1;
        mon_start = cyc;
        smp       = '0;
        smp[0]    = tx_o;
        aborted   = 1'b0;
        for (int unsigned i = 1; i < FRAME; i++) begin
          @(negedge sysclk);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          smp[i] = tx_o;
        end
        mon_busy = 1'b0;
        if (!aborted) begin
          wok = 1'b1;
          for (int unsigned b = 0; b < 10; b++)
            for (int unsigned j = 0; j < BIT; j++)
              if (smp[b*BIT+j] !== smp[b*BIT]) wok = 1'b0;
          for (int unsigned k = 0; k < 8; k++) e.data[k] = smp[(k+1)*BIT + BIT/2];
          e.start      = mon_start;
          e.widths_ok  = wok;
          e.framing_ok = (smp[0] === 1'b0) && (smp[9*BIT] === 1'b1);
          mon_q.push_back(e);
        end
      end
      prev = tx_o;
    end
  end

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (BIT) @(negedge sysclk);
  endtask

  task automatic idle_cycles(input int unsigned n);
    rx_i = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int stop_mid);
    drive_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) drive_bit(b[i]);
    stop_mid = cyc + BIT / 2;
    drive_bit(stop);
  endtask

  task automatic wait_echo(input int unsigned count, input int unsigned budget, output bit ok);
    int unsigned n;
    n = 0;
    while (mon_q.size() < count && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    ok = (mon_q.size() >= count);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         echo;
  } vec_t;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : main
    vec_t       vecs[8];
    echo_t      e, e2;
    logic [7:0] exp_q[$];
    logic [7:0] rb;
    logic       rstop;
    int         mid, mid2, low0;
    int unsigned g, gl;
    bit         ok;

    vecs[0] = '{8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h7E, 1'b1, 1'b1};

    // Reset held with idle line, then a quiet window after release.
    reset_n = 1'b0;
    rx_i    = 1'b1;
    repeat (5) begin
      @(negedge sysclk);
      check("reset_tx_high", tx_o, 1);
    end
    reset_n = 1'b1;
    low0 = tx_low_cnt;
    repeat (40) @(negedge sysclk);
    check("idle_after_reset", tx_low_cnt - low0, 0);

    // Break: line low from reset release onwards.
    reset_n = 1'b0;
    rx_i    = 1'b0;
    repeat (3) @(negedge sysclk);
    reset_n = 1'b1;
    low0 = tx_low_cnt;
    repeat (3 * FRAME) @(negedge sysclk);
    check("break_tx_quiet", tx_low_cnt - low0, 0);
    idle_cycles(FRAME + BIT);
    check("break_no_echo", mon_q.size(), 0);
    check("break_tx_quiet_after", tx_low_cnt - low0, 0);

    // Table-driven single frames.
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop, mid);
      idle_cycles(BIT);
      if (vecs[i].echo) begin
        wait_echo(1, 2 * FRAME, ok);
        check($sformatf("vec%0d_echo_seen", i), ok, 1);
        if (ok) begin
          e = mon_q.pop_front();
          check($sformatf("vec%0d_data", i), e.data, vecs[i].data);
          check($sformatf("vec%0d_bit_widths", i), e.widths_ok, 1);
          check($sformatf("vec%0d_framing", i), e.framing_ok, 1);
          // Midpoint-to-sample: 2 sync cycles plus up to PSC; sample-to-start: up to PSC+1.
          check_range($sformatf("vec%0d_latency", i), e.start - mid, 2, 2 * PSC + 3);
        end
      end else begin
        repeat (FRAME + BIT) @(negedge sysclk);
        check($sformatf("vec%0d_rejected", i), mon_q.size(), 0);
      end
    end

    // Glitch: short low pulse must not start a frame.
    low0 = tx_low_cnt;
    rx_i = 1'b0;
    repeat (4) @(negedge sysclk);
    idle_cycles(FRAME + BIT);
    check("glitch_tx_quiet", tx_low_cnt - low0, 0);
    check("glitch_no_echo", mon_q.size(), 0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, mid);
    send_frame(8'hFF, 1'b1, mid2);
    idle_cycles(BIT);
    wait_echo(2, 3 * FRAME, ok);
    check("b2b_echo_seen", ok, 1);
    if (ok) begin
      e  = mon_q.pop_front();
      e2 = mon_q.pop_front();
      check("b2b_first_data", e.data, 8'h00);
      check("b2b_second_data", e2.data, 8'hFF);
      check("b2b_second_framing", e2.framing_ok && e2.widths_ok, 1);
      check("b2b_no_gap", e2.start - e.start, FRAME);
    end

    // Reset during tx data bit 3, then a clean 0x3C frame.
    send_frame(8'h00, 1'b1, mid);
    rx_i = 1'b1;
    g = 0;
    while (!mon_busy && g < FRAME) begin
      @(negedge sysclk);
      g++;
    end
    check("midrst_tx_started", mon_busy, 1);
    g = 0;
    while (cyc < mon_start + int'(4 * BIT + BIT / 2) && g < 2 * FRAME) begin
      @(negedge sysclk);
      g++;
    end
    check("midrst_tx_low_before", tx_o, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_tx_async_high", tx_o, 1);
    repeat (3) @(negedge sysclk);
    reset_n = 1'b1;
    idle_cycles(BIT);
    check("midrst_no_partial_echo", mon_q.size(), 0);
    send_frame(8'h3C, 1'b1, mid);
    idle_cycles(BIT);
    wait_echo(1, 2 * FRAME, ok);
    check("midrst_echo_seen", ok, 1);
    if (ok) begin
      e = mon_q.pop_front();
      check("midrst_data", e.data, 8'h3C);
      check("midrst_framing", e.framing_ok && e.widths_ok, 1);
    end

    // Randomized traffic: only frames with a valid stop bit are echoed, in order.
    mon_q.delete();
    for (int unsigned n = 0; n < NRAND; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      send_frame(rb, rstop, mid);
      if (rstop) exp_q.push_back(rb);
      g = $urandom_range(0, 2);
      if (!rstop && g == 0) g = 1;
      idle_cycles(g * BIT);
      if ($urandom_range(0, 4) == 0) begin
        idle_cycles(BIT);
        gl = $urandom_range(1, 4);
        rx_i = 1'b0;
        repeat (gl) @(negedge sysclk);
        idle_cycles(BIT);
      end
    end
    idle_cycles(BIT);
    wait_echo(exp_q.size(), 4 * FRAME, ok);
    repeat (BIT) @(negedge sysclk);
    check("rand_count", mon_q.size(), exp_q.size());
    for (int unsigned n = 0; n < exp_q.size() && n < mon_q.size(); n++) begin
      check($sformatf("rand%0d_data", n), mon_q[n].data, exp_q[n]);
      check($sformatf("rand%0d_frame", n), mon_q[n].framing_ok && mon_q[n].widths_ok, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
